// File: rtl/regbank16_scan_8b_pkg.sv
// regbank16_scan_8b_pkg: shared sizes and scan FSM encoding
package regbank16_scan_8b_pkg;
  localparam int IDX_W = 4;
  localparam int NUM_REGS = 16;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/regbank16_scan_8b_bank.sv
// reg16_8b_bank: 16-entry register storage with one write port
module reg16_8b_bank
  import regbank16_scan_8b_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15
);
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    else regs_q <= regs_d;
  end
  assign q0  = regs_q[0];
  assign q1  = regs_q[1];
  assign q2  = regs_q[2];
  assign q3  = regs_q[3];
  assign q4  = regs_q[4];
  assign q5  = regs_q[5];
  assign q6  = regs_q[6];
  assign q7  = regs_q[7];
  assign q8  = regs_q[8];
  assign q9  = regs_q[9];
  assign q10 = regs_q[10];
  assign q11 = regs_q[11];
  assign q12 = regs_q[12];
  assign q13 = regs_q[13];
  assign q14 = regs_q[14];
  assign q15 = regs_q[15];
endmodule

// File: rtl/regbank16_scan_8b.sv
// regbank16_scan_8b: register bank whose words are scanned through an external
// 16:1 mux and streamed out over valid/ready
module regbank16_scan_8b
  import regbank16_scan_8b_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15,
  output logic             sel3,
  output logic             sel2,
  output logic             sel1,
  output logic             sel0,
  input  logic [WIDTH-1:0] mux_out,
  input  logic             start,
  input  logic [IDX_W-1:0] scan_first,
  input  logic [IDX_W-1:0] scan_last,
  input  logic             abort,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d, out_idx_q, out_idx_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, done_q, done_d;
  reg16_8b_bank #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_bank (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .q8(q8), .q9(q9), .q10(q10), .q11(q11), .q12(q12), .q13(q13), .q14(q14), .q15(q15)
  );
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        idx_d   = scan_first;
        last_d  = scan_last;
        state_d = ST_SEL;
      end
      ST_SEL: if (abort) state_d = ST_IDLE;
      else begin
        out_data_d  = mux_out;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: if (abort) begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
        done_d      = idx_q == last_q;
        state_d     = done_d ? ST_IDLE : ST_SEL;
        idx_d       = done_d ? idx_q : idx_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      out_data_q  <= RESET_VAL;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end
  // idx only moves on scan progress, so it doubles as the held mux select
  assign {sel3, sel2, sel1, sel0} = idx_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = state_q != ST_IDLE;
endmodule

// File: tb/tb_regbank16_scan_8b.sv
// tb_regbank16_scan_8b: directed checks of the scan bank driving a 16:1 mux model
module tb_regbank16_scan_8b;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [3:0] wr_addr = '0, scan_first = '0, scan_last = '0, out_idx;
  logic [7:0] wr_data = '0, mux_out, out_data;
  logic [7:0] q0, q1, q2, q3, q4, q5, q6, q7, q8, q9, q10, q11, q12, q13, q14, q15;
  logic sel3, sel2, sel1, sel0, out_valid, busy, done;
  logic [7:0] qa [16];
  logic [7:0] mdl [16];
  logic [3:0] sel;
  int errors = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  regbank16_scan_8b dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5), .q6(q6), .q7(q7),
    .q8(q8), .q9(q9), .q10(q10), .q11(q11), .q12(q12), .q13(q13), .q14(q14), .q15(q15),
    .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0), .mux_out(mux_out),
    .start(start), .scan_first(scan_first), .scan_last(scan_last), .abort(abort),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );
  assign qa[0] = q0;   assign qa[1] = q1;   assign qa[2] = q2;   assign qa[3] = q3;
  assign qa[4] = q4;   assign qa[5] = q5;   assign qa[6] = q6;   assign qa[7] = q7;
  assign qa[8] = q8;   assign qa[9] = q9;   assign qa[10] = q10; assign qa[11] = q11;
  assign qa[12] = q12; assign qa[13] = q13; assign qa[14] = q14; assign qa[15] = q15;
  assign sel = {sel3, sel2, sel1, sel0};
  assign mux_out = qa[sel];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic kick(input logic [3:0] f, input logic [3:0] l);
    start = 1'b1; scan_first = f; scan_last = l;
    step();
    start = 1'b0;
  endtask

  // Call right after the start edge; walks the scan, checking each word and timing.
  task automatic collect(input logic [3:0] first, input int n, input int stall);
    int k = 0, t0 = cyc, last_v = 0;
    bit seen = 0;
    logic [3:0] e;
    logic [7:0] hd;
    for (int c = 0; c < 200 && !seen; c++) begin
      checks++;
      if (out_valid && done) begin errors++; $display("FAIL valid_done_overlap: both high at cycle %0d", cyc); end
      if (out_valid) begin
        e = first + k[3:0];
        checks++;
        if (out_idx !== e) begin errors++; $display("FAIL scan_idx: got %0d want %0d", out_idx, e); end
        checks++;
        if (out_data !== mdl[e]) begin errors++; $display("FAIL scan_data: got %h want %h", out_data, mdl[e]); end
        checks++;
        if (cyc !== (k == 0 ? t0 + 1 : last_v + 2)) begin errors++; $display("FAIL word_latency: word %0d at cycle %0d", k, cyc - t0); end
        if (out_idx == stall) begin
          out_ready = 1'b0;
          hd = out_data;
          repeat (5) begin
            step();
            checks++;
            if (!out_valid || out_data !== hd || out_idx !== e) begin
              errors++; $display("FAIL stall_hold: got v=%b d=%h i=%0d want v=1 d=%h i=%0d", out_valid, out_data, out_idx, hd, e);
            end
          end
          out_ready = 1'b1;
        end
        last_v = cyc;
        k++;
      end
      if (done) begin
        seen = 1;
        checks++;
        if (k !== n) begin errors++; $display("FAIL word_count: got %0d want %0d", k, n); end
        checks++;
        if (cyc !== last_v + 1 || busy) begin errors++; $display("FAIL done_timing: got cycle %0d busy %b want %0d busy 0", cyc, busy, last_v + 1); end
      end
      step();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL scan_timeout: no done, words %0d want %0d", k, n); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || sel !== 4'd0 || out_idx !== 4'd0 || out_data !== 8'h00) begin
      errors++; $display("FAIL reset_state: got v=%b b=%b d=%b sel=%0d idx=%0d data=%h want all 0", out_valid, busy, done, sel, out_idx, out_data);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (qa[i] !== 8'h00) begin errors++; $display("FAIL reset_q%0d: got %h want 00", i, qa[i]); end
      mdl[i] = 8'h00;
    end
    rst = 1'b0;
  endtask

  task automatic test_full_scan();
    for (int i = 0; i < 16; i++) wr(i[3:0], 8'h10 + i[7:0]);
    out_ready = 1'b1;
    kick(4'd0, 4'd15);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL start_busy: got b=%b v=%b want b=1 v=0", busy, out_valid); end
    collect(4'd0, 16, 16);
  endtask

  task automatic test_wrap_stall();
    out_ready = 1'b1;
    kick(4'd14, 4'd1);
    collect(4'd14, 4, 15);
  endtask

  task automatic test_same_edge();
    wr(4'd3, 8'hAA);
    out_ready = 1'b0;
    kick(4'd3, 4'd3);
    checks++;
    if (sel !== 4'd3 || mux_out !== 8'hAA) begin errors++; $display("FAIL sel_drive: got sel=%0d mux=%h want 3 aa", sel, mux_out); end
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    mdl[3] = 8'h55;
    checks++;
    if (out_data !== 8'hAA || out_valid !== 1'b1) begin errors++; $display("FAIL same_edge_capture: got %h v=%b want aa v=1", out_data, out_valid); end
    checks++;
    if (q3 !== 8'h55) begin errors++; $display("FAIL same_edge_write: got %h want 55", q3); end
    out_ready = 1'b1;
    step();
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL same_edge_done: got d=%b v=%b want d=1 v=0", done, out_valid); end
    step();
  endtask

  task automatic test_abort();
    out_ready = 1'b0;
    kick(4'd5, 4'd9);
    start = 1'b1; scan_first = 4'd0; scan_last = 4'd0;
    step();
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd5 || out_data !== mdl[5]) begin
      errors++; $display("FAIL start_ignored: got v=%b idx=%0d data=%h want v=1 idx=5 data=%h", out_valid, out_idx, out_data, mdl[5]);
    end
    abort = 1'b1; out_ready = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_idle: got v=%b b=%b d=%b want 000", out_valid, busy, done); end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sel !== 4'd5) begin errors++; $display("FAIL abort_nodone: got d=%b b=%b sel=%0d want d=0 b=0 sel=5", done, busy, sel); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_in_idle: got b=%b d=%b want 0 0", busy, done); end
    start = 1'b1; abort = 1'b1; scan_first = 4'd2; scan_last = 4'd2;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_over_abort: got busy %b want 1", busy); end
    collect(4'd2, 1, 16);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    kick(4'd7, 4'd7);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 4'd7 || out_data !== mdl[7]) begin
      errors++; $display("FAIL single_word: got v=%b idx=%0d data=%h want v=1 idx=7 data=%h", out_valid, out_idx, out_data, mdl[7]);
    end
    step();
    checks++;
    if ({done, out_valid, busy} !== 3'b100) begin errors++; $display("FAIL single_done: got d=%b v=%b b=%b want 1 0 0", done, out_valid, busy); end
    step();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset_mid_scan();
    out_ready = 1'b0;
    kick(4'd9, 4'd12);
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || sel !== 4'd0 || out_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got v=%b b=%b d=%b sel=%0d data=%h want all 0", out_valid, busy, done, sel, out_data);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (qa[i] !== 8'h00) begin errors++; $display("FAIL mid_reset_q%0d: got %h want 00", i, qa[i]); end
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset: got d=%b b=%b want 0 0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_wrap_stall();
    test_same_edge();
    test_abort();
    test_single();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
